// File: rtl/tqv_reg_arbiter.sv
// Two-requester register-bus arbiter: grants SPI bridge (A) or test sequencer (B)
// round-robin, runs one peripheral read or write, and returns done/err/rdata.
module tqv_reg_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        we_a,
   input  logic        we_b,
   input  logic [1:0]  txn_a,
   input  logic [1:0]  txn_b,
   input  logic [5:0]  addr_a,
   input  logic [5:0]  addr_b,
   input  logic [31:0] wdata_a,
   input  logic [31:0] wdata_b,
   output logic        done_a,
   output logic        done_b,
   output logic        err_a,
   output logic        err_b,
   output logic [31:0] rdata,
   output logic [5:0]  address,
   output logic [31:0] data_in,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_out,
   input  logic        data_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   // Narrow reads return only the addressed byte/half; the rest is zero.
   function automatic logic [31:0] read_mask(input logic [31:0] raw, input logic [1:0] txn);
      logic [31:0] m;
      case (txn)
         2'b00:   m = {24'h000000, raw[7:0]};
         2'b10:   m = raw;
         default: m = {16'h0000, raw[15:0]};
      endcase
      return m;
   endfunction

   state_t      state_r, state_s;
   logic        last_b_r, last_b_s;
   logic        gnt_b_r, gnt_b_s;
   logic        we_r, we_s;
   logic [1:0]  txn_r, txn_s;
   logic [7:0]  wait_r, wait_s;
   logic [5:0]  address_r, address_s;
   logic [31:0] data_in_r, data_in_s;
   logic [1:0]  wr_n_r, wr_n_s;
   logic [1:0]  rd_n_r, rd_n_s;
   logic [31:0] rdata_r, rdata_s;
   logic        done_a_r, done_a_s, done_b_r, done_b_s;
   logic        err_a_r, err_a_s, err_b_r, err_b_s;
   logic        fail_s;
   logic        grant_b_s;

   // Next-state and next-output computation; every output is the registered copy.
   always_comb begin
      state_s   = state_r;
      last_b_s  = last_b_r;
      gnt_b_s   = gnt_b_r;
      we_s      = we_r;
      txn_s     = txn_r;
      wait_s    = wait_r;
      address_s = address_r;
      data_in_s = data_in_r;
      rdata_s   = rdata_r;
      fail_s    = 1'b0;
      grant_b_s = 1'b0;
      wr_n_s    = 2'b11;
      rd_n_s    = 2'b11;
      done_a_s  = 1'b0;
      done_b_s  = 1'b0;
      err_a_s   = 1'b0;
      err_b_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (req_a || req_b) begin
               // On a tie, the side that did not win last time goes first.
               grant_b_s = req_b && (!req_a || !last_b_r);
               gnt_b_s   = grant_b_s;
               last_b_s  = grant_b_s;
               we_s      = grant_b_s ? we_b    : we_a;
               txn_s     = grant_b_s ? txn_b   : txn_a;
               address_s = grant_b_s ? addr_b  : addr_a;
               data_in_s = grant_b_s ? wdata_b : wdata_a;
               state_s   = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            wait_s = 8'd0;
            if (txn_r == 2'b11) begin
               fail_s  = 1'b1;
               state_s = DONE;
            end else if (we_r) begin
               state_s = WRITE;
            end else begin
               state_s = READ;
            end
         end
         WRITE: begin
            state_s = DONE;
         end
         READ: begin
            if (data_ready) begin
               rdata_s = read_mask(data_out, txn_r);
               state_s = DONE;
            end else if (wait_r == LAST_WAIT) begin
               rdata_s = 32'h0000_0000;
               fail_s  = 1'b1;
               state_s = DONE;
            end else begin
               wait_s = wait_r + 8'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (state_s == WRITE) begin
         wr_n_s = txn_r;
      end else begin
         wr_n_s = 2'b11;
      end
      if (state_s == READ) begin
         rd_n_s = txn_r;
      end else begin
         rd_n_s = 2'b11;
      end
      if (state_s == DONE) begin
         done_a_s = !gnt_b_r;
         done_b_s = gnt_b_r;
         err_a_s  = !gnt_b_r && fail_s;
         err_b_s  = gnt_b_r && fail_s;
      end else begin
         done_a_s = 1'b0;
         done_b_s = 1'b0;
      end
   end

   // State and output registers; reset idles the bus and hands priority to A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         last_b_r  <= 1'b1;
         gnt_b_r   <= 1'b0;
         we_r      <= 1'b0;
         txn_r     <= 2'b00;
         wait_r    <= 8'd0;
         address_r <= 6'd0;
         data_in_r <= 32'h0000_0000;
         wr_n_r    <= 2'b11;
         rd_n_r    <= 2'b11;
         rdata_r   <= 32'h0000_0000;
         done_a_r  <= 1'b0;
         done_b_r  <= 1'b0;
         err_a_r   <= 1'b0;
         err_b_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         last_b_r  <= last_b_s;
         gnt_b_r   <= gnt_b_s;
         we_r      <= we_s;
         txn_r     <= txn_s;
         wait_r    <= wait_s;
         address_r <= address_s;
         data_in_r <= data_in_s;
         wr_n_r    <= wr_n_s;
         rd_n_r    <= rd_n_s;
         rdata_r   <= rdata_s;
         done_a_r  <= done_a_s;
         done_b_r  <= done_b_s;
         err_a_r   <= err_a_s;
         err_b_r   <= err_b_s;
      end
   end

   assign done_a       = done_a_r;
   assign done_b       = done_b_r;
   assign err_a        = err_a_r;
   assign err_b        = err_b_r;
   assign rdata        = rdata_r;
   assign address      = address_r;
   assign data_in      = data_in_r;
   assign data_write_n = wr_n_r;
   assign data_read_n  = rd_n_r;

endmodule

// File: tb/tb_tqv_reg_arbiter.sv
// Directed bench for tqv_reg_arbiter: a table of single transactions plus
// hand-written round-robin and mid-transaction reset sequences.
module tb_tqv_reg_arbiter;

   logic        clk, rst_n;
   logic        req_a, req_b, we_a, we_b;
   logic [1:0]  txn_a, txn_b;
   logic [5:0]  addr_a, addr_b;
   logic [31:0] wdata_a, wdata_b;
   logic        done_a, done_b, err_a, err_b;
   logic [31:0] rdata;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n, data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   int checks = 0;
   int errors = 0;

   tqv_reg_arbiter #(.TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .txn_a(txn_a), .txn_b(txn_b), .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .done_a(done_a), .done_b(done_b), .err_a(err_a), .err_b(err_b),
      .rdata(rdata), .address(address), .data_in(data_in),
      .data_write_n(data_write_n), .data_read_n(data_read_n),
      .data_out(data_out), .data_ready(data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // port 0=A 1=B; delay = READ cycles before data_ready (>=255 never);
   // lat = rising edges from request until done is visible.
   typedef struct {
      bit          port;
      bit          we;
      logic [1:0]  txn;
      logic [5:0]  addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] dout;
      bit          ready_idle;
      bit          drop;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
      int          exp_str;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_req(input bit port, input bit val);
      if (port) req_b = val;
      else      req_a = val;
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int e, str, bad, viol;
      bit got;
      e = 0; str = 0; bad = 0; viol = 0; got = 1'b0;
      req_a = 1'b0; req_b = 1'b0;
      if (v.port) begin
         we_b = v.we; txn_b = v.txn; addr_b = v.addr; wdata_b = v.wdata;
      end else begin
         we_a = v.we; txn_a = v.txn; addr_a = v.addr; wdata_a = v.wdata;
      end
      drive_req(v.port, 1'b1);
      data_out   = v.dout;
      data_ready = v.ready_idle;
      while (!got && e < 600) begin
         @(posedge clk); #1;
         e++;
         if (data_write_n != 2'b11 && data_read_n != 2'b11) viol++;
         if (data_write_n != 2'b11) begin
            str++;
            if (data_write_n != v.txn || address != v.addr || data_in != v.wdata) bad++;
         end
         if (data_read_n != 2'b11) begin
            str++;
            if (data_read_n != v.txn || address != v.addr) bad++;
         end
         if (done_a || done_b) begin
            got = 1'b1;
         end else if (data_read_n != 2'b11) begin
            data_ready = (str == v.delay + 1);
         end else begin
            data_ready = v.ready_idle;
         end
         if (v.drop && e == 1) drive_req(v.port, 1'b0);
      end
      chk($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d_latency", idx), 32'(e), 32'(v.exp_lat));
      chk($sformatf("v%0d_done_a", idx), 32'(done_a), 32'(!v.port));
      chk($sformatf("v%0d_done_b", idx), 32'(done_b), 32'(v.port));
      chk($sformatf("v%0d_err_a", idx), 32'(err_a), 32'(!v.port && v.exp_err));
      chk($sformatf("v%0d_err_b", idx), 32'(err_b), 32'(v.port && v.exp_err));
      chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      chk($sformatf("v%0d_strobe_cycles", idx), 32'(str), 32'(v.exp_str));
      chk($sformatf("v%0d_strobe_fields", idx), 32'(bad), 32'd0);
      chk($sformatf("v%0d_both_strobes", idx), 32'(viol), 32'd0);
      drive_req(v.port, 1'b0);
      data_ready = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_clear", idx), 32'(done_a | done_b), 32'd0);
   endtask

   initial begin
      int n, quiet;
      bit exp_a;
      rst_n = 1'b1;
      req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      txn_a = 2'b00; txn_b = 2'b00; addr_a = 6'd0; addr_b = 6'd0;
      wdata_a = 32'h0; wdata_b = 32'h0; data_out = 32'h0; data_ready = 1'b0;

      //            port we  txn    addr   wdata         dly  dout          ri   drop rdata         err lat  str
      vecs[0] = '{1'b0, 1'b1, 2'b10, 6'h05, 32'hDEADBEEF, 0,   32'h0,        1'b0, 1'b0, 32'h00000000, 1'b0, 3,   1};
      vecs[1] = '{1'b1, 1'b0, 2'b00, 6'h01, 32'h0,        3,   32'h12345678, 1'b1, 1'b0, 32'h00000078, 1'b0, 6,   4};
      vecs[2] = '{1'b0, 1'b0, 2'b01, 6'h02, 32'h0,        0,   32'hCAFEF00D, 1'b0, 1'b0, 32'h0000F00D, 1'b0, 3,   1};
      vecs[3] = '{1'b1, 1'b0, 2'b10, 6'h3F, 32'h0,        1,   32'hA5A55A5A, 1'b0, 1'b1, 32'hA5A55A5A, 1'b0, 4,   2};
      vecs[4] = '{1'b0, 1'b1, 2'b00, 6'h10, 32'h000000FF, 0,   32'h0,        1'b0, 1'b0, 32'hA5A55A5A, 1'b0, 3,   1};
      vecs[5] = '{1'b1, 1'b1, 2'b11, 6'h20, 32'h11111111, 0,   32'h0,        1'b0, 1'b0, 32'hA5A55A5A, 1'b1, 2,   0};
      vecs[6] = '{1'b0, 1'b0, 2'b11, 6'h21, 32'h0,        0,   32'hFFFFFFFF, 1'b1, 1'b0, 32'hA5A55A5A, 1'b1, 2,   0};
      vecs[7] = '{1'b1, 1'b0, 2'b10, 6'h07, 32'h0,        999, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 257, 255};
      vecs[8] = '{1'b0, 1'b0, 2'b10, 6'h08, 32'h0,        254, 32'h13579BDF, 1'b0, 1'b0, 32'h13579BDF, 1'b0, 257, 255};
      vecs[9] = '{1'b0, 1'b0, 2'b01, 6'h03, 32'h0,        0,   32'h1234BEEF, 1'b0, 1'b0, 32'h0000BEEF, 1'b0, 3,   1};

      // Asynchronous reset: outputs must clear before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_write_n", 32'(data_write_n), 32'd3);
      chk("rst_read_n", 32'(data_read_n), 32'd3);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data_in", data_in, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_done_err", 32'({done_a, done_b, err_a, err_b}), 32'd0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

      // Round robin with both held: fresh reset so A wins the first tie.
      #3 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
      we_a = 1'b1; we_b = 1'b1; txn_a = 2'b10; txn_b = 2'b10;
      addr_a = 6'h0A; addr_b = 6'h0B; wdata_a = 32'hAAAA0000; wdata_b = 32'hBBBB0000;
      req_a = 1'b1; req_b = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(posedge clk); #1;
         if (done_a || done_b) begin
            exp_a = (n % 2 == 0);
            chk($sformatf("rr%0d_done_a", n), 32'(done_a), 32'(exp_a));
            chk($sformatf("rr%0d_done_b", n), 32'(done_b), 32'(!exp_a));
            n++;
            if (n == 4) begin
               req_a = 1'b0; req_b = 1'b0;
            end
         end
      end
      chk("rr_done_count", 32'(n), 32'd4);
      @(posedge clk); #1;

      // Reset during READ drops the transaction without done or re-issue.
      we_a = 1'b0; txn_a = 2'b10; addr_a = 6'h03; req_a = 1'b1;
      n = 0;
      while (data_read_n == 2'b11 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rstmid_read_started", 32'(data_read_n), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_read_n", 32'(data_read_n), 32'd3);
      chk("rstmid_done", 32'(done_a | done_b), 32'd0);
      req_a = 1'b0;
      #12 rst_n = 1'b1;
      quiet = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done_a || done_b || data_read_n != 2'b11 || data_write_n != 2'b11) quiet++;
      end
      chk("rstmid_quiet_after", 32'(quiet), 32'd0);
      run_txn(9, vecs[9]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tqv_reg_arbiter.md
TQV_REG_ARBITER -- requirements
Module: tqv_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving max cycles a read waits for data_ready before aborting.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_a / req_b  input  1  requester A (SPI bridge) / B (test sequencer) transaction request, level, held until done.
REQ-005 SHALL have ports we_a / we_b  input  1  1=write, 0=read.
REQ-006 SHALL have ports txn_a / txn_b  input  2  width: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have ports addr_a / addr_b  input  6  register address.
REQ-008 SHALL have ports wdata_a / wdata_b  input  32  write data.
REQ-009 SHALL have ports done_a / done_b  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports err_a / err_b  output  1  valid with done: timeout or illegal width.
REQ-011 SHALL have port rdata  output  32  read result, valid with done, held until next done.
REQ-012 SHALL have ports address  output  6, data_in  output  32, data_write_n  output  2, data_read_n  output  2  peripheral register bus.
REQ-013 SHALL have ports data_out  input  32, data_ready  input  1  peripheral read return.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> (WRITE | READ) -> DONE -> IDLE; all bus outputs registered.
REQ-015 IDLE: if any req, SHALL grant one requester, latch its we/txn/addr/wdata, go ISSUE next cycle.
REQ-016 Both req same cycle: SHALL grant the requester not granted last; after reset A has priority.
REQ-017 ISSUE with txn=11: SHALL skip bus access, go DONE with err=1, rdata unchanged.
REQ-018 WRITE: data_write_n SHALL equal latched txn for exactly one cycle, address/data_in valid that cycle; then DONE.
REQ-019 READ: data_read_n SHALL equal latched txn from entry until the cycle data_ready is sampled high (inclusive), then 11.
REQ-020 READ capture: rdata SHALL be data_out with [31:16] zeroed unless txn=10 and [15:8] zeroed if txn=00.
REQ-021 READ: 8-bit wait counter counts cycles in READ; on reaching TIMEOUT without data_ready SHALL release strobe, set rdata=0, err=1, go DONE.
REQ-022 data_ready in the same cycle as timeout SHALL win: data captured, err=0.
REQ-023 DONE: SHALL pulse done (and err) for the granted requester only, for one cycle, then IDLE.
REQ-024 Min transaction latency: write req->done 4 cycles; read with data_ready on first READ cycle 4 cycles.
REQ-025 Request deasserted mid-transaction SHALL NOT abort; done still pulses.
REQ-026 Requester held high after done SHALL be treated as a new request, subject to round-robin.
REQ-027 Outside WRITE/READ, data_write_n and data_read_n SHALL be 11; never both non-11.
REQ-028 data_ready outside READ SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, data_write_n=11, data_read_n=11, address=0, data_in=0, rdata=0, done_*=0, err_*=0, counter=0, last-grant=B.
REQ-030 Reset mid-transaction SHALL drop it without done; no re-issue after release.

Verification
V1: req_a write txn=10 addr=0x05 wdata=0xDEADBEEF -> one cycle data_write_n=00... =10, address=0x05, data_in=0xDEADBEEF; done_a at cycle 4, err_a=0.
V2: req_b read txn=00 addr=0x01, data_ready 3 cycles later with data_out=0x12345678 -> rdata=0x00000078, done_b, err_b=0.
V3: req_a and req_b asserted together, held -> grants A, B, A, B alternating; no done on wrong port.
V4: read with data_ready never asserted, TIMEOUT=255 -> strobe released after 255 READ cycles, rdata=0, err=1 with done.
V5: txn=11 request -> no strobe ever leaves 11, done with err=1.
V6: rst_n low during READ -> data_read_n=11 same instant, no done after release, next request serviced normally.
